pong_match_ctrl: RTL and testbench

//  Match sequencer for the Pong scoring datapath. Watches the one-cycle

---
 rtl/pong_match_ctrl_if.sv | 27 ++
 rtl/pong_match_ctrl.sv | 150 +++++++++++++++
 tb/tb_pong_match_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pong_match_ctrl_if.sv
// Player-input, score and ball-control bundle between the match sequencer and its neighbours.
// The slave modport is the sequencer's view of this bundle.
interface pong_match_ctrl_if #(
  parameter int SCORE_W = 7
);
  logic               start;
  logic               pause;
  logic [1:0]         increaseScore;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic               ball_run;
  logic               ball_recenter;
  logic               score_clear;
  logic               serve_dir;
  logic [1:0]         winner;
  logic [2:0]         state_o;

  modport slave (
    input  start, pause, increaseScore, score1, score2,
    output ball_run, ball_recenter, score_clear, serve_dir, winner, state_o
  );

  modport master (
    output start, pause, increaseScore, score1, score2,
    input  ball_run, ball_recenter, score_clear, serve_dir, winner, state_o
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve countdown, ball gating, point handling and winner detection.
// Every output is a flop, so pulses and ball_run lag their cause by one edge.
module pong_match_ctrl #(
  parameter int SCORE_W     = 7,
  parameter int WIN_SCORE   = 11,
  parameter int SERVE_DELAY = 50000000
) (
  input  logic            clk,
  input  logic            reset,
  pong_match_ctrl_if.slave bus
);

  localparam int TIMER_W = $clog2(SERVE_DELAY + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SERVE_DELAY - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_PLAY       = 3'd2,
    ST_POINT      = 3'd3,
    ST_GAME_OVER  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               ball_run_q, ball_run_d;
  logic               ball_recenter_q, ball_recenter_d;
  logic               score_clear_q, score_clear_d;
  logic               serve_dir_q, serve_dir_d;
  logic [1:0]         winner_q, winner_d;

  // Per-player "reached the winning score" flags; index 0 is P1.
  logic [SCORE_W-1:0] score_arr [2];
  logic [1:0]         at_limit;

  assign score_arr[0] = bus.score1;
  assign score_arr[1] = bus.score2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_limit
      assign at_limit[gi] = (score_arr[gi] >= WIN_VAL);
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      timer_q         <= '0;
      ball_run_q      <= 1'b0;
      ball_recenter_q <= 1'b0;
      score_clear_q   <= 1'b0;
      serve_dir_q     <= 1'b0;
      winner_q        <= 2'b00;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      ball_run_q      <= ball_run_d;
      ball_recenter_q <= ball_recenter_d;
      score_clear_q   <= score_clear_d;
      serve_dir_q     <= serve_dir_d;
      winner_q        <= winner_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    ball_run_d      = 1'b0;
    ball_recenter_d = 1'b0;
    score_clear_d   = 1'b0;
    serve_dir_d     = serve_dir_q;
    winner_d        = winner_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d         = ST_SERVE_WAIT;
          timer_d         = '0;
          score_clear_d   = 1'b1;
          ball_recenter_d = 1'b1;
        end
      end

      ST_SERVE_WAIT: begin
        // Paused cycles do not count toward the serve delay.
        if (!bus.pause) begin
          if (timer_q == TIMER_LAST) begin
            state_d    = ST_PLAY;
            timer_d    = '0;
            ball_run_d = 1'b1;
          end else begin
            timer_d = timer_q + TIMER_ONE;
          end
        end
      end

      ST_PLAY: begin
        ball_run_d = ~bus.pause;
        if (bus.increaseScore == 2'b01) begin
          state_d     = ST_POINT;
          serve_dir_d = 1'b0;
          ball_run_d  = 1'b0;
        end else if (bus.increaseScore == 2'b10) begin
          state_d     = ST_POINT;
          serve_dir_d = 1'b1;
          ball_run_d  = 1'b0;
        end
      end

      ST_POINT: begin
        if (at_limit[0]) begin
          state_d  = ST_GAME_OVER;
          winner_d = 2'b01;
        end else if (at_limit[1]) begin
          state_d  = ST_GAME_OVER;
          winner_d = 2'b10;
        end else begin
          state_d         = ST_SERVE_WAIT;
          timer_d         = '0;
          ball_recenter_d = 1'b1;
        end
      end

      ST_GAME_OVER: begin
        if (bus.start) begin
          state_d         = ST_SERVE_WAIT;
          timer_d         = '0;
          winner_d        = 2'b00;
          score_clear_d   = 1'b1;
          ball_recenter_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  assign bus.ball_run      = ball_run_q;
  assign bus.ball_recenter = ball_recenter_q;
  assign bus.score_clear   = score_clear_q;
  assign bus.serve_dir     = serve_dir_q;
  assign bus.winner        = winner_q;
  assign bus.state_o       = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: a cycle model built from the match rules checks every output each
// cycle, and literal expectations at key points pin the model itself.
module tb_pong_match_ctrl;

  localparam int SCORE_W     = 7;
  localparam int WIN_SCORE   = 3;
  localparam int SERVE_DELAY = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  pong_match_ctrl_if #(.SCORE_W(SCORE_W)) bus ();

  pong_match_ctrl #(
    .SCORE_W    (SCORE_W),
    .WIN_SCORE  (WIN_SCORE),
    .SERVE_DELAY(SERVE_DELAY)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Match model: phase uses the published state numbering; serve_left counts unpaused
  // cycles still to wait before the ball is released.
  typedef struct {
    int         phase;
    int         serve_left;
    bit         run;
    bit         rec;
    bit         clr;
    bit         dir;
    logic [1:0] win;
  } mdl_t;

  mdl_t m = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};

  function automatic mdl_t begin_serve(input mdl_t cur);
    mdl_t n = cur;
    n.phase      = 1;
    n.serve_left = SERVE_DELAY;
    n.rec        = 1'b1;
    return n;
  endfunction

  function automatic mdl_t step(input mdl_t cur, input bit st, input bit pz,
                                input logic [1:0] inc, input int s1, input int s2);
    mdl_t n = cur;
    n.run = 1'b0;
    n.rec = 1'b0;
    n.clr = 1'b0;
    if ((cur.phase == 0 || cur.phase == 4) && st) begin
      n     = begin_serve(n);
      n.clr = 1'b1;
      n.win = 2'b00;
    end else if (cur.phase == 1 && !pz) begin
      n.serve_left = cur.serve_left - 1;
      if (n.serve_left == 0) begin
        n.phase = 2;
        n.run   = 1'b1;
      end
    end else if (cur.phase == 2) begin
      n.run = !pz;
      if (inc == 2'b01 || inc == 2'b10) begin
        n.phase = 3;
        n.dir   = (inc == 2'b10);
        n.run   = 1'b0;
      end
    end else if (cur.phase == 3) begin
      if (s1 >= WIN_SCORE)      begin n.phase = 4; n.win = 2'b01; end
      else if (s2 >= WIN_SCORE) begin n.phase = 4; n.win = 2'b10; end
      else                      n = begin_serve(n);
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    else m <= step(m, bus.start, bus.pause, bus.increaseScore,
                   int'(bus.score1), int'(bus.score2));
  end

  always @(negedge clk) begin
    chk("model_state",    int'(bus.state_o),       m.phase);
    chk("model_run",      int'(bus.ball_run),      int'(m.run));
    chk("model_recenter", int'(bus.ball_recenter), int'(m.rec));
    chk("model_clear",    int'(bus.score_clear),   int'(m.clr));
    chk("model_dir",      int'(bus.serve_dir),     int'(m.dir));
    chk("model_winner",   int'(bus.winner),        int'(m.win));
  end

  // Inputs change 2 time units after each rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic score_point(input logic [1:0] who);
    bus.increaseScore = who;
    tick();
    bus.increaseScore = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.increaseScore = 2'b00;
    bus.score1 = '0;
    bus.score2 = '0;
    tick(2);
    reset = 1'b0;
    tick();
    chk("idle_state", int'(bus.state_o), 0);
    chk("idle_run", int'(bus.ball_run), 0);
    $display("txn reset-release: state=%0d", bus.state_o);

    // Start from IDLE: one-cycle clear/recenter, ball released 4 cycles later.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_state", int'(bus.state_o), 1);
    chk("start_clear", int'(bus.score_clear), 1);
    chk("start_recenter", int'(bus.ball_recenter), 1);
    tick();
    chk("start_clear_gone", int'(bus.score_clear), 0);
    chk("start_recenter_gone", int'(bus.ball_recenter), 0);
    tick(2);
    chk("serve_hold_run", int'(bus.ball_run), 0);
    tick();
    chk("serve_done_state", int'(bus.state_o), 2);
    chk("serve_done_run", int'(bus.ball_run), 1);
    $display("txn start: state=%0d run=%0d", bus.state_o, bus.ball_run);

    // Start held through PLAY has no effect.
    bus.start = 1'b1;
    tick(3);
    bus.start = 1'b0;
    chk("held_start_state", int'(bus.state_o), 2);
    chk("held_start_clear", int'(bus.score_clear), 0);
    $display("txn held-start: state=%0d", bus.state_o);

    // Pause in PLAY drops ball_run one edge later; illegal increaseScore ignored.
    bus.pause = 1'b1;
    tick();
    chk("pause_run", int'(bus.ball_run), 0);
    bus.pause = 1'b0;
    tick();
    chk("unpause_run", int'(bus.ball_run), 1);
    score_point(2'b11);
    chk("illegal_inc_state", int'(bus.state_o), 2);
    $display("txn pause/illegal: state=%0d run=%0d", bus.state_o, bus.ball_run);

    // P2 scores 1: POINT, then serve again without clearing scores.
    bus.score2 = 7'd1;
    score_point(2'b10);
    chk("point_state", int'(bus.state_o), 3);
    chk("point_run", int'(bus.ball_run), 0);
    chk("point_dir", int'(bus.serve_dir), 1);
    tick();
    chk("reserve_state", int'(bus.state_o), 1);
    chk("reserve_recenter", int'(bus.ball_recenter), 1);
    chk("reserve_clear", int'(bus.score_clear), 0);
    $display("txn point-p2: state=%0d dir=%0d", bus.state_o, bus.serve_dir);

    // Three paused cycles push the serve out to 7 cycles; increaseScore ignored here.
    bus.pause = 1'b1;
    tick(3);
    bus.pause = 1'b0;
    score_point(2'b01);
    chk("serve_ignore_inc", int'(bus.state_o), 1);
    tick(2);
    chk("paused_serve_hold", int'(bus.state_o), 1);
    tick();
    chk("paused_serve_play", int'(bus.state_o), 2);
    chk("paused_serve_run", int'(bus.ball_run), 1);
    $display("txn paused-serve: state=%0d", bus.state_o);

    // P2 reaches 3: game over, further points ignored, restart clears winner.
    bus.score2 = 7'd3;
    score_point(2'b10);
    tick();
    chk("win_state", int'(bus.state_o), 4);
    chk("win_winner", int'(bus.winner), 2);
    chk("win_run", int'(bus.ball_run), 0);
    bus.score1 = 7'd1;
    score_point(2'b01);
    tick();
    chk("over_ignore_inc", int'(bus.state_o), 4);
    chk("over_winner_held", int'(bus.winner), 2);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.score1 = '0;
    bus.score2 = '0;
    chk("restart_winner", int'(bus.winner), 0);
    chk("restart_clear", int'(bus.score_clear), 1);
    chk("restart_dir_kept", int'(bus.serve_dir), 1);
    $display("txn win-p2/restart: state=%0d winner=%0d", bus.state_o, bus.winner);

    // Both players at the limit: P1 takes priority.
    tick(4);
    bus.score1 = 7'd3;
    bus.score2 = 7'd3;
    score_point(2'b10);
    tick();
    chk("tie_winner", int'(bus.winner), 1);
    chk("tie_state", int'(bus.state_o), 4);
    $display("txn tie: winner=%0d", bus.winner);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.score1 = '0;
    bus.score2 = '0;

    // Asynchronous reset mid-PLAY, between edges.
    tick(4);
    chk("pre_reset_state", int'(bus.state_o), 2);
    #1;
    reset = 1'b1;
    #1;
    chk("async_reset_state", int'(bus.state_o), 0);
    chk("async_reset_run", int'(bus.ball_run), 0);
    chk("async_reset_dir", int'(bus.serve_dir), 0);
    tick();
    reset = 1'b0;
    tick(3);
    chk("post_reset_idle", int'(bus.state_o), 0);
    $display("txn async-reset: state=%0d", bus.state_o);

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
